shot_tracker: RTL and testbench

- Tracks the player's shots, hits, birds and score for each duck and each round.
- Produces the `no_shots_left`, `bird_shot` and `game_over` status inputs consumed by the game control FSM.
- Consumes that FSM's `new_duck`, `reset_shots`, `reset_score`, `reset_birds` and `state` outputs.
- Feeds the HUD: shells remaining, 4-digit BCD score, and a per-bird hit map.

---
 rtl/shot_tracker.sv | 159 +++++++++++++++
 tb/tb_shot_tracker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/shot_tracker.sv
// rtl/shot_tracker.sv - shot, hit, bird and BCD score tracking for the duck hunt game
module shot_tracker #(
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int NUM_BIRDS       = 10,
  parameter int POINTS_HUNDREDS = 5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 trigger,
  input  logic                 hit_detect,
  input  logic                 new_duck,
  input  logic                 reset_shots,
  input  logic                 reset_score,
  input  logic                 reset_birds,
  input  logic [1:0]           state,
  output logic                 no_shots_left,
  output logic                 bird_shot,
  output logic                 game_over,
  output logic [1:0]           shots_left,
  output logic [15:0]          score,
  output logic [3:0]           birds_done,
  output logic [3:0]           birds_hit,
  output logic [NUM_BIRDS-1:0] hit_map
);

  localparam logic [1:0] SHOTS_INIT = 2'(SHOTS_PER_DUCK);
  localparam logic [4:0] NB         = 5'(NUM_BIRDS);
  localparam logic [4:0] PTS        = 5'(POINTS_HUNDREDS);
  localparam logic [1:0] ST_PLAY    = 2'b10;

  logic                 sync1_q, sync2_q, prev_q;
  logic [1:0]           shots_left_q, shots_left_d;
  logic                 bird_shot_q, bird_shot_d;
  logic [15:0]          score_q, score_d;
  logic [3:0]           birds_done_q, birds_done_d;
  logic [3:0]           birds_hit_q, birds_hit_d;
  logic [NUM_BIRDS-1:0] hit_map_q, hit_map_d;

  logic        fire;
  logic        shot_ok;
  logic        shot_take;
  logic        hit_take;
  logic        map_valid;
  logic [4:0]  hund_sum;
  logic [4:0]  hund_adj;
  logic        hund_carry;
  logic [4:0]  thou_sum;
  logic [15:0] score_add;

  // Trigger is asynchronous: two-flop synchronizer followed by an edge register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= trigger;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fire    = sync2_q & ~prev_q;
  assign shot_ok = fire & (state == ST_PLAY) & (shots_left_q != 2'd0) & ~bird_shot_q;
  // A reload or a new duck in the same cycle owns the duck registers, so the shot is dropped whole.
  assign shot_take = shot_ok & ~reset_shots & ~new_duck;
  assign hit_take  = shot_take & hit_detect;
  assign map_valid = (birds_done_q != 4'd0) && ({1'b0, birds_done_q} <= NB);

  // BCD add of the per-hit points into the hundreds digit, carrying into thousands, saturating at 9999.
  always_comb begin
    hund_sum   = {1'b0, score_q[11:8]} + PTS;
    hund_carry = (hund_sum > 5'd9);
    hund_adj   = hund_carry ? (hund_sum - 5'd10) : hund_sum;
    thou_sum   = {1'b0, score_q[15:12]} + {4'd0, hund_carry};
    if (thou_sum > 5'd9) begin
      score_add = 16'h9999;
    end else begin
      score_add = {thou_sum[3:0], hund_adj[3:0], score_q[7:0]};
    end
  end

  // Next-state for every counter, with reset_* > new_duck > shot priority per register.
  always_comb begin
    shots_left_d = shots_left_q;
    bird_shot_d  = bird_shot_q;
    score_d      = score_q;
    birds_done_d = birds_done_q;
    birds_hit_d  = birds_hit_q;
    hit_map_d    = hit_map_q;

    if (reset_shots) begin
      shots_left_d = SHOTS_INIT;
      bird_shot_d  = 1'b0;
    end else if (new_duck) begin
      bird_shot_d  = 1'b0;
    end else if (shot_take) begin
      shots_left_d = shots_left_q - 2'd1;
      if (hit_detect) begin
        bird_shot_d = 1'b1;
      end
    end

    if (reset_score) begin
      score_d = 16'h0000;
    end else if (hit_take) begin
      score_d = score_add;
    end

    if (reset_birds) begin
      birds_done_d = 4'd0;
      birds_hit_d  = 4'd0;
      hit_map_d    = '0;
    end else begin
      if (new_duck && (birds_done_q != 4'd15)) begin
        birds_done_d = birds_done_q + 4'd1;
      end
      if (hit_take) begin
        if (birds_hit_q != 4'd15) begin
          birds_hit_d = birds_hit_q + 4'd1;
        end
        for (int i = 0; i < NUM_BIRDS; i++) begin
          if (map_valid && (birds_done_q == 4'(i + 1))) begin
            hit_map_d[i] = 1'b1;
          end
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shots_left_q <= SHOTS_INIT;
      bird_shot_q  <= 1'b0;
      score_q      <= 16'h0000;
      birds_done_q <= 4'd0;
      birds_hit_q  <= 4'd0;
      hit_map_q    <= '0;
    end else begin
      shots_left_q <= shots_left_d;
      bird_shot_q  <= bird_shot_d;
      score_q      <= score_d;
      birds_done_q <= birds_done_d;
      birds_hit_q  <= birds_hit_d;
      hit_map_q    <= hit_map_d;
    end
  end

  assign shots_left    = shots_left_q;
  assign bird_shot     = bird_shot_q;
  assign score         = score_q;
  assign birds_done    = birds_done_q;
  assign birds_hit     = birds_hit_q;
  assign hit_map       = hit_map_q;
  assign no_shots_left = (shots_left_q == 2'd0);
  assign game_over     = ({1'b0, birds_done_q} >= NB);

endmodule

// File: tb/tb_shot_tracker.sv
// tb/tb_shot_tracker.sv - directed self-checking bench for shot_tracker
module tb_shot_tracker;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        trigger = 1'b0;
  logic        hit_detect = 1'b0;
  logic        new_duck = 1'b0;
  logic        reset_shots = 1'b0;
  logic        reset_score = 1'b0;
  logic        reset_birds = 1'b0;
  logic [1:0]  state = 2'b00;
  logic        no_shots_left, bird_shot, game_over;
  logic [1:0]  shots_left;
  logic [15:0] score;
  logic [3:0]  birds_done, birds_hit;
  logic [9:0]  hit_map;

  int errors = 0;
  int checks = 0;

  shot_tracker #(.SHOTS_PER_DUCK(3), .NUM_BIRDS(10), .POINTS_HUNDREDS(5)) dut (
    .Clk(Clk), .Reset(Reset), .trigger(trigger), .hit_detect(hit_detect),
    .new_duck(new_duck), .reset_shots(reset_shots), .reset_score(reset_score),
    .reset_birds(reset_birds), .state(state), .no_shots_left(no_shots_left),
    .bird_shot(bird_shot), .game_over(game_over), .shots_left(shots_left),
    .score(score), .birds_done(birds_done), .birds_hit(birds_hit), .hit_map(hit_map)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Clean trigger pulse: the shot lands on the third edge; then let the edge detector settle.
  task automatic shoot(input logic hit);
    hit_detect = hit;
    trigger = 1'b1;
    tick(3);
    trigger = 1'b0;
    hit_detect = 1'b0;
    tick(3);
  endtask

  task automatic pulse_reload();
    reset_shots = 1'b1;
    tick(1);
    reset_shots = 1'b0;
  endtask

  task automatic pulse_duck();
    new_duck = 1'b1;
    tick(1);
    new_duck = 1'b0;
  endtask

  initial begin
    tick(2);
    Reset = 1'b0;
    check("rst_shots_left", {14'd0, shots_left}, 16'd3);
    check("rst_score", score, 16'h0000);
    check("rst_flags", {13'd0, no_shots_left, bird_shot, game_over}, 16'd0);
    check("rst_birds", {8'd0, birds_done, birds_hit}, 16'd0);
    check("rst_hit_map", {6'd0, hit_map}, 16'd0);

    state = 2'b10;
    pulse_duck();
    check("duck1_done", {12'd0, birds_done}, 16'd1);

    // Miss: shots_left drops exactly three edges after trigger rises.
    trigger = 1'b1;
    tick(2);
    check("lat_before", {14'd0, shots_left}, 16'd3);
    tick(1);
    check("lat_at3", {14'd0, shots_left}, 16'd2);
    trigger = 1'b0;
    tick(3);
    check("miss_score", score, 16'h0000);
    check("miss_bird_shot", {15'd0, bird_shot}, 16'd0);

    // Held trigger with crosshair on the duck: exactly one hit.
    pulse_reload();
    hit_detect = 1'b1;
    trigger = 1'b1;
    tick(50);
    trigger = 1'b0;
    hit_detect = 1'b0;
    tick(3);
    check("hold_shots", {14'd0, shots_left}, 16'd2);
    check("hold_bird_shot", {15'd0, bird_shot}, 16'd1);
    check("hold_score", score, 16'h0500);
    check("hold_birds_hit", {12'd0, birds_hit}, 16'd1);
    check("hold_hit_map", {6'd0, hit_map}, 16'h0001);

    // Duck already hit: further fire is ignored.
    shoot(1'b1);
    check("shot_after_hit", {14'd0, shots_left}, 16'd2);
    check("score_after_hit", score, 16'h0500);

    // Empty the gun, then one more trigger.
    pulse_duck();
    pulse_reload();
    check("duck2_bird_shot", {15'd0, bird_shot}, 16'd0);
    check("duck2_done", {12'd0, birds_done}, 16'd2);
    shoot(1'b0);
    shoot(1'b0);
    shoot(1'b0);
    check("empty_shots", {14'd0, shots_left}, 16'd0);
    check("empty_flag", {15'd0, no_shots_left}, 16'd1);
    shoot(1'b1);
    check("dry_fire_shots", {14'd0, shots_left}, 16'd0);
    check("dry_fire_score", score, 16'h0500);

    // Wrong phase.
    pulse_reload();
    state = 2'b01;
    shoot(1'b1);
    check("state01_shots", {14'd0, shots_left}, 16'd3);
    state = 2'b11;
    shoot(1'b1);
    check("state11_shots", {14'd0, shots_left}, 16'd3);
    check("state_score", score, 16'h0500);
    state = 2'b10;

    // Shot coinciding with a reload is lost.
    reset_shots = 1'b1;
    hit_detect = 1'b1;
    trigger = 1'b1;
    tick(3);
    reset_shots = 1'b0;
    trigger = 1'b0;
    hit_detect = 1'b0;
    tick(3);
    check("reload_clash_shots", {14'd0, shots_left}, 16'd3);
    check("reload_clash_score", score, 16'h0500);

    // BCD carry and saturation on duck 2.
    shoot(1'b1);
    check("bcd_carry", score, 16'h1000);
    check("hit_map_duck2", {6'd0, hit_map}, 16'h0003);
    for (int i = 0; i < 17; i++) begin
      pulse_reload();
      shoot(1'b1);
    end
    check("score_9500", score, 16'h9500);
    pulse_reload();
    shoot(1'b1);
    check("score_sat", score, 16'h9999);
    pulse_reload();
    shoot(1'b1);
    check("score_sat_hold", score, 16'h9999);
    check("birds_hit_sat", {12'd0, birds_hit}, 16'd15);

    reset_score = 1'b1;
    tick(1);
    reset_score = 1'b0;
    check("reset_score", score, 16'h0000);

    // Full round of ducks.
    reset_birds = 1'b1;
    tick(1);
    reset_birds = 1'b0;
    check("rb_hit_map", {6'd0, hit_map}, 16'd0);
    check("rb_counts", {8'd0, birds_done, birds_hit}, 16'd0);
    for (int i = 0; i < 9; i++) begin
      pulse_duck();
      pulse_reload();
    end
    check("go_after9", {15'd0, game_over}, 16'd0);
    new_duck = 1'b1;
    tick(1);
    new_duck = 1'b0;
    check("go_after10", {15'd0, game_over}, 16'd1);
    check("done_10", {12'd0, birds_done}, 16'd10);

    // Hit on the last shell of duck 10.
    pulse_reload();
    shoot(1'b0);
    shoot(1'b0);
    shoot(1'b1);
    check("last_shell_flags", {14'd0, bird_shot, no_shots_left}, 16'd3);
    check("last_shell_map", {6'd0, hit_map}, 16'h0200);
    check("last_shell_score", score, 16'h0500);

    reset_birds = 1'b1;
    tick(1);
    reset_birds = 1'b0;
    check("rb_game_over", {15'd0, game_over}, 16'd0);
    check("rb_hit_map2", {6'd0, hit_map}, 16'd0);

    // Reset with a fire in flight.
    pulse_reload();
    trigger = 1'b1;
    hit_detect = 1'b1;
    tick(1);
    trigger = 1'b0;
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    tick(4);
    hit_detect = 1'b0;
    check("midreset_shots", {14'd0, shots_left}, 16'd3);
    check("midreset_score", score, 16'h0000);
    check("midreset_bird_shot", {15'd0, bird_shot}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
